// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types for the countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/prescaler.sv
// rtl/prescaler.sv - up-counter that wraps at divide and flags a tick on the wrap cycle
module prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] divide,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = enable && !clear && (cnt == divide);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == divide) ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable down-counting timer with sticky expiry interrupt
module countdown_timer
  import timer_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [SIZE-1:0]       load_value,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  irq_ack,
  output logic [SIZE-1:0]       count_value,
  output logic                  busy,
  output logic                  expired,
  output logic                  overrun
);

  timer_state_t          state;
  logic [SIZE-1:0]       reload;
  logic [PRESCALE_W-1:0] divide;
  logic                  periodic_mode;
  logic                  tick;
  logic                  expiry;

  prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (state == RUN),
    .divide (divide),
    .tick   (tick)
  );

  // A start or stop on the same edge discards the pending tick entirely
  assign expiry = (state == RUN) && tick && (count_value == '0) && !start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count_value   <= '0;
      reload        <= '0;
      divide        <= '0;
      periodic_mode <= 1'b0;
      busy          <= 1'b0;
      expired       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        reload        <= load_value;
        divide        <= prescale;
        periodic_mode <= periodic;
        count_value   <= load_value;
        state         <= RUN;
        busy          <= 1'b1;
      end else if (state == RUN && tick) begin
        if (count_value != '0) begin
          count_value <= count_value - SIZE'(1);
        end else if (periodic_mode) begin
          count_value <= reload;
        end else begin
          state <= EXPIRED;
          busy  <= 1'b0;
        end
      end

      // Set beats ack; overrun only latches when the previous expiry is still unacknowledged
      if (expiry) begin
        expired <= 1'b1;
        if (irq_ack) begin
          overrun <= 1'b0;
        end else if (expired) begin
          overrun <= 1'b1;
        end
      end else if (irq_ack) begin
        expired <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
